// File: rtl/ides8_align_pkg.sv
// Shared types and sizing helpers for the IDES8 word-alignment checker.
package ides8_align_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SLIP,
    WAIT,
    LOCKED,
    FAIL
  } state_e;

  localparam logic [7:0] PATTERN_DEFAULT   = 8'h55;
  localparam int         LOCK_CNT_DEFAULT  = 16;
  localparam int         LOSS_CNT_DEFAULT  = 4;
  localparam int         SLIP_WAIT_DEFAULT = 3;
  localparam int         MAX_SLIP_DEFAULT  = 16;
  localparam int         ERR_W_DEFAULT     = 16;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int MATCH_W_DEFAULT = cnt_w(LOCK_CNT_DEFAULT);
  localparam int MISS_W_DEFAULT  = cnt_w(LOSS_CNT_DEFAULT);
  localparam int WAIT_W_DEFAULT  = cnt_w(SLIP_WAIT_DEFAULT);
  localparam int SLIP_W_DEFAULT  = cnt_w(MAX_SLIP_DEFAULT);

endpackage

// File: rtl/ides8_sat_cnt.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
module ides8_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         nrst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] val_o
);

  logic [W-1:0] r_val;

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      r_val <= '0;
    end else if (clr_i) begin
      r_val <= '0;
    end else if (inc_i && (r_val != {W{1'b1}})) begin
      r_val <= r_val + 1'b1;
    end
  end

  assign val_o = r_val;

endmodule

// File: rtl/ides8_align_checker.sv
// IDES8 receive word aligner: bit-slips via CALIB until the training pattern locks, then counts errors.
// Optional IDES8_ALIGN_CAPTURE_EN adds bad_word_o, the first word that mismatched while locked.
//
//  state  | meaning
//  IDLE   | disabled; status outputs low, counters hold last values
//  CHECK  | counting consecutive pattern matches toward lock
//  SLIP   | CALIB pulse cycle (bit-slip requested)
//  WAIT   | IDES8 settling after a slip, data ignored
//  LOCKED | aligned; mismatches counted as errors
//  FAIL   | slip budget exhausted without lock, sticky until en_i drops
module ides8_align_checker
  import ides8_align_pkg::*;
#(
  parameter logic [7:0] PATTERN   = PATTERN_DEFAULT,
  parameter int         LOCK_CNT  = LOCK_CNT_DEFAULT,
  parameter int         LOSS_CNT  = LOSS_CNT_DEFAULT,
  parameter int         SLIP_WAIT = SLIP_WAIT_DEFAULT,
  parameter int         MAX_SLIP  = MAX_SLIP_DEFAULT,
  parameter int         ERR_W     = ERR_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             en_i,
  input  logic [7:0]       q_i,
  output logic             calib_o,
  output logic             locked_o,
  output logic             fail_o,
  output logic [2:0]       slip_cnt_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic             err_o
`ifdef IDES8_ALIGN_CAPTURE_EN
  ,
  output logic [7:0]       bad_word_o
`endif
);

  localparam int MATCH_W = cnt_w(LOCK_CNT);
  localparam int MISS_W  = cnt_w(LOSS_CNT);
  localparam int WAIT_W  = cnt_w(SLIP_WAIT);
  localparam int SLIP_W  = cnt_w(MAX_SLIP);

  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_CNT - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [SLIP_W-1:0]  SLIP_LIMIT = SLIP_W'(MAX_SLIP);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [MATCH_W-1:0]   r_match_cnt;
  logic [MATCH_W-1:0]   w_match_nxt;
  logic [MISS_W-1:0]    r_miss_cnt;
  logic [MISS_W-1:0]    w_miss_nxt;
  logic [WAIT_W-1:0]    r_wait_cnt;
  logic [WAIT_W-1:0]    w_wait_nxt;
  logic [2:0]           r_slip_phase;
  logic                 r_calib;
  logic                 r_locked;
  logic                 r_fail;
  logic                 r_err;
  logic [SLIP_W-1:0]    w_slip_total;
  logic [ERR_W-1:0]     w_err_cnt;

  logic                 w_match;
  logic                 w_start;
  logic                 w_slip_issue;
  logic                 w_err_hit;

  assign w_match      = (q_i == PATTERN);
  assign w_start      = en_i && (r_state == IDLE);
  assign w_slip_issue = (w_state_nxt == SLIP);
  // en_i low wins over a simultaneous mismatch, so the error is not counted
  assign w_err_hit    = en_i && (r_state == LOCKED) && !w_match;

  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match_cnt;
    w_miss_nxt  = r_miss_cnt;
    w_wait_nxt  = r_wait_cnt;

    if (!en_i) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = CHECK;
          w_match_nxt = '0;
          w_miss_nxt  = '0;
        end

        CHECK: begin
          if (w_match) begin
            if (r_match_cnt == MATCH_LAST) begin
              w_state_nxt = LOCKED;
              w_match_nxt = '0;
              w_miss_nxt  = '0;
            end else begin
              w_match_nxt = r_match_cnt + 1'b1;
            end
          end else begin
            w_match_nxt = '0;
            w_state_nxt = (w_slip_total == SLIP_LIMIT) ? FAIL : SLIP;
          end
        end

        SLIP: begin
          if (SLIP_WAIT == 0) begin
            w_state_nxt = CHECK;
            w_match_nxt = '0;
          end else begin
            w_state_nxt = WAIT;
            w_wait_nxt  = WAIT_LAST;
          end
        end

        WAIT: begin
          if (r_wait_cnt == '0) begin
            w_state_nxt = CHECK;
            w_match_nxt = '0;
          end else begin
            w_wait_nxt = r_wait_cnt - 1'b1;
          end
        end

        LOCKED: begin
          if (w_match) begin
            w_miss_nxt = '0;
          end else if (r_miss_cnt == MISS_LAST) begin
            w_state_nxt = CHECK;
            w_match_nxt = '0;
            w_miss_nxt  = '0;
          end else begin
            w_miss_nxt = r_miss_cnt + 1'b1;
          end
        end

        FAIL: begin
          w_state_nxt = FAIL;
        end

        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      r_state      <= IDLE;
      r_match_cnt  <= '0;
      r_miss_cnt   <= '0;
      r_wait_cnt   <= '0;
      r_slip_phase <= '0;
      r_calib      <= 1'b0;
      r_locked     <= 1'b0;
      r_fail       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_match_cnt <= w_match_nxt;
      r_miss_cnt  <= w_miss_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_calib     <= w_slip_issue;
      r_locked    <= (w_state_nxt == LOCKED);
      r_fail      <= (w_state_nxt == FAIL);
      r_err       <= w_err_hit;
      // phase index counts on the same edge calib_o rises
      if (w_start) begin
        r_slip_phase <= '0;
      end else if (w_slip_issue) begin
        r_slip_phase <= r_slip_phase + 1'b1;
      end
    end
  end

  ides8_sat_cnt #(
    .W (SLIP_W)
  ) u_slip_total (
    .clk_i  (clk_i),
    .nrst_i (nrst_i),
    .clr_i  (w_start),
    .inc_i  (w_slip_issue),
    .val_o  (w_slip_total)
  );

  ides8_sat_cnt #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk_i  (clk_i),
    .nrst_i (nrst_i),
    .clr_i  (w_start),
    .inc_i  (w_err_hit),
    .val_o  (w_err_cnt)
  );

`ifdef IDES8_ALIGN_CAPTURE_EN
  logic [7:0] r_bad_word;
  logic       r_bad_held;

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      r_bad_word <= '0;
      r_bad_held <= 1'b0;
    end else if (!en_i) begin
      r_bad_word <= '0;
      r_bad_held <= 1'b0;
    end else if (w_err_hit && !r_bad_held) begin
      r_bad_word <= q_i;
      r_bad_held <= 1'b1;
    end
  end

  assign bad_word_o = r_bad_word;
`endif

  assign calib_o    = r_calib;
  assign locked_o   = r_locked;
  assign fail_o     = r_fail;
  assign slip_cnt_o = r_slip_phase;
  assign err_cnt_o  = w_err_cnt;
  assign err_o      = r_err;

endmodule
